// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the architectural $zero register index.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the stall and
// flush statistics of the hazard controller.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller for the 5-stage MIPS core: pipeline enables/flushes for
// load-use stalls, taken-branch flushes and multi-cycle data-memory waits.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned SW_FWD_EN = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_mem_write,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam int unsigned       WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic              mw, lu, rs_hit, rt_hit, rt_exempt, br_act;

    assign mw        = mem_access && !dmem_ready;
    assign rs_hit    = id_uses_rs && (id_rs == ex_rd);
    // A store's rt is only store data; the forwarding unit supplies it late.
    assign rt_exempt = (SW_FWD_EN != 0) && id_mem_write;
    assign rt_hit    = id_uses_rt && (id_rt == ex_rd) && !rt_exempt;
    assign lu        = ex_mem_read && (ex_rd != REG_ZERO) && (rs_hit || rt_hit);
    assign br_act    = reset_n && ex_branch_taken && !mw;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = RUN;
        unique case (state_q)
            MEM_WAIT: begin
                if (mw)                    state_d = MEM_WAIT;
                else if (ex_branch_taken)  state_d = RUN;
                else if (lu)               state_d = LU_STALL;
            end
            default: begin
                if (mw)                    state_d = MEM_WAIT;
                else if (ex_branch_taken)  state_d = RUN;
                else if (lu)               state_d = LU_STALL;
            end
        endcase
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        memwb_flush = 1'b0;
        if (!reset_n) begin
            memwb_flush = 1'b1;
        end else if (mw) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Wait counter tracks consecutive wait cycles; the timeout flag is sticky.
    always_comb begin
        wait_d    = '0;
        timeout_d = timeout_q;
        if (mw) begin
            wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
            if (wait_d == WAIT_MAX) timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .clear_i (1'b0),
        .inc_i   (!pc_en),
        .count_o (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .clear_i (1'b0),
        .inc_i   (br_act),
        .count_o (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: instance A uses store-data
// forwarding, instance B does not and has 3-bit counters to hit saturation.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rs, id_uses_rt, id_mem_write;
    logic       ex_mem_read, ex_branch_taken, mem_access, dmem_ready;

    logic        a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_flush;
    logic        a_exmem_en, a_memwb_flush, a_timeout;
    logic [15:0] a_stall, a_flush;
    logic        b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_flush;
    logic        b_exmem_en, b_memwb_flush, b_timeout;
    logic [2:0]  b_stall, b_flush;
    logic [6:0]  a_ctrl, b_ctrl;

    // Control vector order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en memwb_flush
    localparam logic [6:0] C_RESET = 7'b1101011;
    localparam logic [6:0] C_IDLE  = 7'b1101010;
    localparam logic [6:0] C_MW    = 7'b0000001;
    localparam logic [6:0] C_BR    = 7'b1111110;
    localparam logic [6:0] C_LU    = 7'b0001110;
    localparam int         TMO     = 4;

    assign a_ctrl = {a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_flush, a_exmem_en, a_memwb_flush};
    assign b_ctrl = {b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_flush, b_exmem_en, b_memwb_flush};

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.CNT_W(16), .TIMEOUT(TMO), .SW_FWD_EN(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_mem_write(id_mem_write),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(a_pc_en), .ifid_en(a_ifid_en), .ifid_flush(a_ifid_flush),
        .idex_en(a_idex_en), .idex_flush(a_idex_flush), .exmem_en(a_exmem_en),
        .memwb_flush(a_memwb_flush), .stall_cnt(a_stall), .flush_cnt(a_flush),
        .mem_timeout(a_timeout)
    );

    hazard_stall_ctrl #(.CNT_W(3), .TIMEOUT(TMO), .SW_FWD_EN(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_mem_write(id_mem_write),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(b_pc_en), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_flush),
        .idex_en(b_idex_en), .idex_flush(b_idex_flush), .exmem_en(b_exmem_en),
        .memwb_flush(b_memwb_flush), .stall_cnt(b_stall), .flush_cnt(b_flush),
        .mem_timeout(b_timeout)
    );

    typedef struct {
        logic [6:0] ctrl_a, ctrl_b;
        int         stall_a, stall_b, flush_a, flush_b;
        logic       to_a, to_b;
    } exp_t;

    exp_t sb[$];
    int   err_cnt = 0;
    int   chk_cnt = 0;
    int   m_stall[2] = '{0, 0};
    int   m_flush[2] = '{0, 0};
    int   m_wait[2]  = '{0, 0};
    bit   m_to[2]    = '{0, 0};
    int   cmax[2]    = '{65535, 7};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_ctrl(input bit fwd);
        logic lu, mw;
        mw = mem_access && !dmem_ready;
        lu = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_uses_rs && id_rs == ex_rd) ||
              (id_uses_rt && id_rt == ex_rd && !(fwd && id_mem_write)));
        if (!reset_n)             return C_RESET;
        else if (mw)              return C_MW;
        else if (ex_branch_taken) return C_BR;
        else if (lu)              return C_LU;
        return C_IDLE;
    endfunction

    task automatic model_update(input int k, input logic [6:0] c);
        if (!reset_n) begin
            m_stall[k] = 0; m_flush[k] = 0; m_wait[k] = 0; m_to[k] = 0;
        end else begin
            if (!c[6] && m_stall[k] < cmax[k]) m_stall[k]++;
            if (c == C_BR && m_flush[k] < cmax[k]) m_flush[k]++;
            if (mem_access && !dmem_ready) begin
                if (m_wait[k] < TMO) m_wait[k]++;
                if (m_wait[k] >= TMO) m_to[k] = 1'b1;
            end else begin
                m_wait[k] = 0;
            end
        end
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check("a_ctrl",  32'(a_ctrl),    32'(e.ctrl_a));
        check("b_ctrl",  32'(b_ctrl),    32'(e.ctrl_b));
        check("a_stall", 32'(a_stall),   32'(e.stall_a));
        check("b_stall", 32'(b_stall),   32'(e.stall_b));
        check("a_flush", 32'(a_flush),   32'(e.flush_a));
        check("b_flush", 32'(b_flush),   32'(e.flush_b));
        check("a_tmo",   32'(a_timeout), 32'(e.to_a));
        check("b_tmo",   32'(b_timeout), 32'(e.to_b));
    endtask

    // Args: rn, ex_mem_read, ex_rd, uses_rs, rs, uses_rt, rt, mem_write, branch, mem_access, ready
    task automatic step(input logic rn, input logic mrd, input logic [4:0] rd,
                        input logic urs, input logic [4:0] rs, input logic urt,
                        input logic [4:0] rt, input logic mwr, input logic br,
                        input logic macc, input logic rdy);
        exp_t       e;
        logic [6:0] c0, c1;
        reset_n = rn; ex_mem_read = mrd; ex_rd = rd; id_uses_rs = urs; id_rs = rs;
        id_uses_rt = urt; id_rt = rt; id_mem_write = mwr; ex_branch_taken = br;
        mem_access = macc; dmem_ready = rdy;
        c0 = exp_ctrl(1'b1);
        c1 = exp_ctrl(1'b0);
        e.ctrl_a = c0;         e.ctrl_b = c1;
        e.stall_a = m_stall[0]; e.stall_b = m_stall[1];
        e.flush_a = m_flush[0]; e.flush_b = m_flush[1];
        e.to_a = m_to[0];       e.to_b = m_to[1];
        sb.push_back(e);
        @(negedge clk);
        compare();
        model_update(0, c0);
        model_update(1, c1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        // load-use on rs
        step(1, 1, 8, 1, 8, 0, 0, 0, 0, 0, 1);
        idle();
        // store-data dependency: exempt only with forwarding
        step(1, 1, 9, 0, 0, 1, 9, 1, 0, 0, 1);
        idle();
        // rt dependency of a non-store always stalls
        step(1, 1, 10, 0, 0, 1, 10, 0, 0, 0, 1);
        idle();
        // $zero destination never stalls
        step(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        // back-to-back load-use (re-detected in LU_STALL)
        step(1, 1, 11, 1, 11, 0, 0, 0, 0, 0, 1);
        step(1, 1, 11, 1, 11, 0, 0, 0, 0, 0, 1);
        idle();
        // branch with simultaneous load-use
        step(1, 1, 8, 1, 8, 0, 0, 0, 1, 0, 1);
        idle();
        // three-cycle memory wait, then advance (B stall counter saturates)
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle();
        // branch frozen during memory wait, flushed once on release
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        idle();
        // reset asserted mid-stall
        step(1, 1, 12, 1, 12, 0, 0, 0, 0, 0, 1);
        step(0, 1, 12, 1, 12, 0, 0, 0, 0, 0, 1);
        idle();
        // timeout: long wait, sticky flag, then cleared by reset
        repeat (9) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();
        idle();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
